// File: rtl/rca_multiword_sequencer.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit ripple-carry slice processes a nibble per clock.
// Optional signed-overflow output is enabled by defining RCA_SEQ_OVF_EN.

module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[4];
  end
endmodule

module rca_multiword_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef RCA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int NIBBLES   = WIDTH / 4;
  localparam int NIB_CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [NIB_CNT_W-1:0] LAST_IDX = NIB_CNT_W'(NIBBLES - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("rca_multiword_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  // Handshake: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid-side data is held stable until that edge.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]       sum_q, sum_d;
  logic [NIB_CNT_W-1:0]   idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic                   cout_q, cout_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
`ifdef RCA_SEQ_OVF_EN
  logic                   ovf_q, ovf_d;
`endif

  logic [3:0] slice_a, slice_b, slice_sum;
  logic       slice_cout;

  ripple_carry_adder_4bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d       = ovf_q;
`endif
    slice_a     = a_q[4*idx_q +: 4];
    slice_b     = b_q[4*idx_q +: 4];

    case (state_q)
      S_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone completes the handshake
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[4*idx_q +: 4] = slice_sum;
        carry_d             = slice_cout;
        idx_d               = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d      = slice_cout;
`ifdef RCA_SEQ_OVF_EN
          // carry into the MSB recovered from the MSB sum bit
          ovf_d       = (slice_a[3] ^ slice_b[3] ^ slice_sum[3]) ^ slice_cout;
`endif
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef RCA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_multiword_sequencer.sv
// Scoreboarded bench for rca_multiword_sequencer (WIDTH=16); ovf is checked when RCA_SEQ_OVF_EN is defined.

module tb_rca_multiword_sequencer;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rand_ready = 1'b0;

  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  rca_multiword_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef RCA_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

`ifndef RCA_SEQ_OVF_EN
  assign ovf = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: full-precision arithmetic, packed as {ovf, cout, sum}
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rc);
    logic [W:0] full;
    logic       v;
    full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
    v    = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
    return {v, full};
  endfunction

  // driver: call at a negedge
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    bit ok = 1'b0;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    if (ok) begin
      exp_q.push_back(ref_model(ta, tb, tc));
      acc_q.push_back(cyc);
    end else begin
      check("send_timeout", 1'b1, 1'b0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", W'(exp_q.size()), '0);
      exp_q.delete();
      acc_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // monitor / scoreboard
  logic         prev_valid = 1'b0;
  logic [W+1:0] held;
  always @(negedge clk) begin
    logic [W+1:0] exp;
    int           at;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else if (out_valid) begin
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1'b1, 1'b0);
        end else begin
          exp = exp_q.pop_front();
          at  = acc_q.pop_front();
          check("sum", sum, exp[W-1:0]);
          check("cout", cout, exp[W]);
`ifdef RCA_SEQ_OVF_EN
          check("ovf", ovf, exp[W+1]);
`endif
          check("latency", (W+2)'(cyc - at), (W+2)'(NIB));
        end
        held = {ovf, cout, sum};
      end else begin
        check("hold_stable", {ovf, cout, sum}, held);
      end
      check("in_ready_busy", in_ready, 1'b0);
    end
    prev_valid = out_valid;
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vectors
    out_ready = 1'b1;
    send(16'h1234, 16'h4321, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);
    send(16'h0000, 16'h0000, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_drain();

    // backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    send(16'h00F0, 16'h0010, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("bp_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = W'($urandom); b = W'($urandom);
      check("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);
    send(16'h0001, 16'h0001, 1'b0);
    wait_drain();

    // reset during RUN
    send(16'h8888, 16'h8888, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, '0);
    check("mid_rst_cout", cout, 1'b0);
    check("mid_rst_ovf", ovf, 1'b0);
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);
    end

    // randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      idle_cycles($urandom_range(0, 2));
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
